// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared MIPS opcode constants and fetch state encoding
package mips_defs;

    localparam logic [5:0]  OP_RTYPE         = 6'b000000;
    localparam logic [5:0]  OP_J             = 6'b000010;
    localparam logic [5:0]  OP_JAL           = 6'b000011;
    localparam logic [5:0]  FUNC_SYSCALL     = 6'b001100;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

    function automatic logic [5:0] func_of(input logic [31:0] word);
        return word[5:0];
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - instruction memory and decode-side signals of the fetch stage
interface inst_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;

    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_word;
    logic [ADDR_W-1:0] inst_pc;
    logic [5:0]        opcode;
    logic [5:0]        func;
    logic              fetch_halted;

    // master is the fetch stage itself; slave is memory plus decode
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_pc, halted,
        output inst_valid,
        input  inst_ready,
        output inst_word, inst_pc, opcode, func, fetch_halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect, redirect_pc, halted,
        input  inst_valid,
        output inst_ready,
        input  inst_word, inst_pc, opcode, func, fetch_halted
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with +4 step and word-aligned redirect load
module fetch_pc_reg #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              inc_en,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

    // load beats increment so a redirect in the ack cycle drops the +4
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc & ALIGN_MASK;
        end else if (inc_en) begin
            pc <= pc + PC_STEP;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch stage: pc, single outstanding imem request, instruction register
module inst_fetch
    import mips_defs::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic           clk,
    input  logic           rst_b,
    inst_fetch_if.master   bus
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       inst_word_q;
    logic [ADDR_W-1:0] inst_pc_q;

    logic accept;
    logic halt_accept;
    logic pc_load;
    logic pc_inc;

    assign accept      = (state == HOLD) && bus.inst_ready;
    assign halt_accept = accept && bus.halted;
    // halt outranks redirect, and HALT ignores redirects entirely
    assign pc_load     = bus.redirect && (state != HALT) && !halt_accept;
    assign pc_inc      = (state == REQ) && bus.imem_ack && !bus.redirect;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst_b   (rst_b),
        .inc_en  (pc_inc),
        .load    (pc_load),
        .load_pc (bus.redirect_pc),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= IDLE;
            inst_word_q <= '0;
            inst_pc_q   <= '0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (bus.redirect) begin
                        state <= REQ;
                    end else if (bus.imem_ack) begin
                        inst_word_q <= bus.imem_rdata;
                        inst_pc_q   <= pc;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (halt_accept) begin
                        state <= HALT;
                    end else if (bus.redirect || accept) begin
                        state <= REQ;
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.imem_req     = (state == REQ);
    assign bus.imem_addr    = pc;
    assign bus.inst_valid   = (state == HOLD);
    assign bus.fetch_halted = (state == HALT);
    assign bus.inst_word    = inst_word_q;
    assign bus.inst_pc      = inst_pc_q;
    assign bus.opcode       = opcode_of(inst_word_q);
    assign bus.func         = func_of(inst_word_q);

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
module tb_inst_fetch;
    import mips_defs::*;

    typedef struct {
        int          lat;
        int          stall;
        int          gap;
        logic [31:0] pc;
        logic [31:0] word;
        logic [5:0]  op;
        logic [5:0]  fn;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_b;
    int          checks = 0;
    int          errors = 0;
    vec_t        vec [4];
    exp_t        exp_q [$];
    int          mem_lat = 0;
    logic        mem_ack = 1'b0;
    logic        force_ack = 1'b0;
    int          wait_cnt = 0;
    logic        prev_req = 1'b0;
    logic [31:0] last_addr = '0;

    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(32)) bus ();

    inst_fetch #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0000_0020;
            32'h0000_0004: mem_word = {OP_J, 26'h000_0040};
            32'h0000_0008: mem_word = 32'h2008_0005;
            32'h0000_000C: mem_word = {OP_JAL, 26'h000_0103};
            32'h0000_0100: mem_word = 32'h8C09_0004;
            32'h0000_0104: mem_word = {OP_RTYPE, 20'h0_0000, FUNC_SYSCALL};
            default:       mem_word = {~a[15:0], a[15:0]};
        endcase
    endfunction

    assign bus.imem_ack   = mem_ack | force_ack;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.inst_valid && cyc < 40);
        if (!bus.inst_valid) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout actual=0 required=1");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(bus.imem_req), 32'h0);
        check({tag, "_addr"},  bus.imem_addr, 32'h0);
        check({tag, "_valid"}, 32'(bus.inst_valid), 32'h0);
        check({tag, "_word"},  bus.inst_word, 32'h0);
        check({tag, "_pc"},    bus.inst_pc, 32'h0);
        check({tag, "_halt"},  32'(bus.fetch_halted), 32'h0);
    endtask

    // scoreboard pop on accept, then memory model decides this cycle's ack
    always @(negedge clk) begin : mem_and_monitor
        exp_t e;
        if (rst_b && bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow actual_pc=%h required=queued_word", bus.inst_pc);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc",     bus.inst_pc, e.pc);
                check("sb_word",   bus.inst_word, e.word);
                check("sb_opcode", 32'(bus.opcode), 32'(e.word[31:26]));
                check("sb_func",   32'(bus.func), 32'(e.word[5:0]));
            end
        end
        mem_ack = 1'b0;
        if (rst_b && bus.imem_req) begin
            if (!prev_req || bus.imem_addr != last_addr) wait_cnt = 0;
            else wait_cnt++;
            mem_ack = (wait_cnt >= mem_lat);
            if ((mem_ack || force_ack) && !bus.redirect)
                exp_q.push_back('{bus.imem_addr, mem_word(bus.imem_addr)});
        end
        prev_req  = rst_b && bus.imem_req;
        last_addr = bus.imem_addr;
    end

    initial begin
        int cyc;
        vec[0] = '{0, 0, 2, 32'h0000_0000, 32'h0000_0020, 6'h00, 6'h20};
        vec[1] = '{0, 0, 2, 32'h0000_0004, 32'h0800_0040, 6'h02, 6'h00};
        vec[2] = '{3, 5, 5, 32'h0000_0008, 32'h2008_0005, 6'h08, 6'h05};
        vec[3] = '{1, 0, 3, 32'h0000_000C, 32'h0C00_0103, 6'h03, 6'h03};

        rst_b           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halted      = 1'b0;
        bus.inst_ready  = 1'b1;
        tick();
        tick();
        check_reset_outputs("rst0");
        rst_b = 1'b1;

        for (int i = 0; i < 4; i++) begin
            mem_lat = vec[i].lat;
            wait_valid(cyc);
            check($sformatf("v%0d_gap", i),    32'(cyc), 32'(vec[i].gap));
            check($sformatf("v%0d_pc", i),     bus.inst_pc, vec[i].pc);
            check($sformatf("v%0d_word", i),   bus.inst_word, vec[i].word);
            check($sformatf("v%0d_opcode", i), 32'(bus.opcode), 32'(vec[i].op));
            check($sformatf("v%0d_func", i),   32'(bus.func), 32'(vec[i].fn));
            check($sformatf("v%0d_req", i),    32'(bus.imem_req), 32'h0);
            check($sformatf("v%0d_nextpc", i), bus.imem_addr, vec[i].pc + 32'd4);
            if (vec[i].stall > 0) begin
                bus.inst_ready = 1'b0;
                bus.halted     = 1'b1;
                for (int s = 0; s < vec[i].stall; s++) begin
                    tick();
                    check($sformatf("v%0d_stall%0d_valid", i, s), 32'(bus.inst_valid), 32'h1);
                    check($sformatf("v%0d_stall%0d_word", i, s),  bus.inst_word, vec[i].word);
                    check($sformatf("v%0d_stall%0d_pc", i, s),    bus.inst_pc, vec[i].pc);
                    check($sformatf("v%0d_stall%0d_req", i, s),   32'(bus.imem_req), 32'h0);
                end
                bus.halted     = 1'b0;
                bus.inst_ready = 1'b1;
            end
        end

        // redirect while waiting on 0x10, with a coincident ack to be discarded
        mem_lat = 5;
        tick();
        check("rd_addr_before", bus.imem_addr, 32'h0000_0010);
        check("rd_req_before",  32'(bus.imem_req), 32'h1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        force_ack       = 1'b1;
        tick();
        bus.redirect = 1'b0;
        force_ack    = 1'b0;
        mem_lat      = 0;
        check("rd_addr_after", bus.imem_addr, 32'h0000_0100);
        check("rd_req_after",  32'(bus.imem_req), 32'h1);
        check("rd_valid",      32'(bus.inst_valid), 32'h0);
        wait_valid(cyc);
        check("rd_gap",  32'(cyc), 32'h1);
        check("rd_pc",   bus.inst_pc, 32'h0000_0100);
        check("rd_word", bus.inst_word, 32'h8C09_0004);

        // syscall accepted together with a redirect: halt wins
        wait_valid(cyc);
        check("halt_gap",    32'(cyc), 32'h2);
        check("halt_pc",     bus.inst_pc, 32'h0000_0104);
        check("halt_word",   bus.inst_word, 32'h0000_000C);
        check("halt_opcode", 32'(bus.opcode), 32'(OP_RTYPE));
        check("halt_func",   32'(bus.func), 32'(FUNC_SYSCALL));
        bus.halted      = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        tick();
        bus.halted   = 1'b0;
        bus.redirect = 1'b0;
        check("halt_flag",  32'(bus.fetch_halted), 32'h1);
        check("halt_valid", 32'(bus.inst_valid), 32'h0);
        check("halt_req",   32'(bus.imem_req), 32'h0);
        check("halt_addr",  bus.imem_addr, 32'h0000_0108);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0300;
        force_ack       = 1'b1;
        tick();
        bus.redirect = 1'b0;
        repeat (3) tick();
        force_ack = 1'b0;
        check("halt_sticky", 32'(bus.fetch_halted), 32'h1);
        check("halt_valid2", 32'(bus.inst_valid), 32'h0);
        check("halt_req2",   32'(bus.imem_req), 32'h0);
        check("halt_addr2",  bus.imem_addr, 32'h0000_0108);

        // reset out of HALT, redirect in IDLE to 0x40, then reset mid-request
        rst_b = 1'b0;
        exp_q.delete();
        tick();
        check_reset_outputs("rst1");
        mem_lat         = 10;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0041;
        rst_b           = 1'b1;
        tick();
        bus.redirect = 1'b0;
        check("idle_rd_addr", bus.imem_addr, 32'h0000_0040);
        check("idle_rd_req",  32'(bus.imem_req), 32'h1);
        tick();
        check("midreq_addr", bus.imem_addr, 32'h0000_0040);
        #2;
        rst_b = 1'b0;
        #1;
        check_reset_outputs("rst2");
        exp_q.delete();
        tick();
        mem_lat = 0;
        rst_b   = 1'b1;
        wait_valid(cyc);
        check("restart_gap",  32'(cyc), 32'h2);
        check("restart_pc",   bus.inst_pc, 32'h0000_0000);
        check("restart_word", bus.inst_word, 32'h0000_0020);
        tick();
        check("sb_drain", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
